// File: rtl/ttl_updown_counter.sv
// Presettable synchronous up/down counter with programmable modulus and a cascade carry.
// State changes only while the supply pins are valid.
module ttl_updown_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2 ** WIDTH
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             VCC,
    input  logic             GND,
    input  logic             LOAD_N,
    input  logic [WIDTH-1:0] D,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             MAX_MIN,
    output logic             RCO
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);

    logic             powered;
    logic             clr_gated_n;
    logic [WIDTH-1:0] q_d, q_q;

    assign powered = VCC & ~GND;
    // Clear reaches the register only while powered, so an unpowered device ignores it.
    assign clr_gated_n = CLR_N | ~powered;

    always_comb begin
        q_d = q_q;
        if (powered) begin
            if (!LOAD_N) begin
                q_d = ({1'b0, D} >= ModExt) ? MaxVal : D;
            end else if (ENP && ENT) begin
                if (UP) begin
                    q_d = (q_q == MaxVal) ? '0 : q_q + 1'b1;
                end else begin
                    q_d = (q_q == '0) ? MaxVal : q_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge clr_gated_n) begin
        if (!clr_gated_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q       = q_q;
    assign MAX_MIN = UP ? (q_q == MaxVal) : (q_q == '0);
    assign RCO     = ENT & MAX_MIN;

endmodule

// File: tb/tb_ttl_updown_counter.sv
// Directed bench for ttl_updown_counter: decade instance plus a two-stage hex cascade.
module tb_ttl_updown_counter;

    logic       clk;
    logic       clr_n, vcc, gnd, load_n, enp, ent, up;
    logic [3:0] d;
    logic [3:0] q;
    logic       max_min, rco;

    logic       c_clr_n, c_enp;
    logic [3:0] lo_q, hi_q;
    logic       lo_mm, lo_rco, hi_mm, hi_rco;

    int tests_run;
    int tests_failed;

    ttl_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dec (
        .CLK(clk), .CLR_N(clr_n), .VCC(vcc), .GND(gnd), .LOAD_N(load_n), .D(d),
        .ENP(enp), .ENT(ent), .UP(up), .Q(q), .MAX_MIN(max_min), .RCO(rco)
    );

    ttl_updown_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
        .CLK(clk), .CLR_N(c_clr_n), .VCC(1'b1), .GND(1'b0), .LOAD_N(1'b1), .D(4'd0),
        .ENP(c_enp), .ENT(1'b1), .UP(1'b1), .Q(lo_q), .MAX_MIN(lo_mm), .RCO(lo_rco)
    );

    ttl_updown_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
        .CLK(clk), .CLR_N(c_clr_n), .VCC(1'b1), .GND(1'b0), .LOAD_N(1'b1), .D(4'd0),
        .ENP(c_enp), .ENT(lo_rco), .UP(1'b1), .Q(hi_q), .MAX_MIN(hi_mm), .RCO(hi_rco)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_q;
        int cnt;
        tests_run    = 0;
        tests_failed = 0;
        vcc = 1'b1; gnd = 1'b0; clr_n = 1'b1; load_n = 1'b1; d = 4'd0;
        enp = 1'b0; ent = 1'b0; up = 1'b1;
        c_clr_n = 1'b1; c_enp = 1'b0;

        // Reset
        #1;
        clr_n = 1'b0; c_clr_n = 1'b0;
        #1;
        check_eq("rst_q", q, 0);
        check_eq("rst_maxmin_up", max_min, 0);
        check_eq("rst_rco_up", rco, 0);
        up = 1'b0; ent = 1'b1;
        #1;
        check_eq("rst_maxmin_dn", max_min, 1);
        check_eq("rst_rco_dn", rco, 1);
        up = 1'b1;
        #1;
        check_eq("updir_flips_maxmin", max_min, 0);
        @(negedge clk);
        clr_n = 1'b1; c_clr_n = 1'b1;

        // Decade count up
        enp = 1'b1; ent = 1'b1; up = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_q = i % 10;
            check_eq($sformatf("dec_q_%0d", i), q, exp_q);
            check_eq($sformatf("dec_rco_%0d", i), rco, (exp_q == 9) ? 1 : 0);
        end

        // Down count and wrap
        @(negedge clk);
        load_n = 1'b0; d = 4'd2;
        tick();
        check_eq("dn_load", q, 2);
        @(negedge clk);
        load_n = 1'b0; d = 4'd2;
        load_n = 1'b1; up = 1'b0;
        begin
            int dn_exp[4] = '{1, 0, 9, 8};
            for (int i = 0; i < 4; i++) begin
                tick();
                check_eq($sformatf("dn_q_%0d", i), q, dn_exp[i]);
                check_eq($sformatf("dn_mm_%0d", i), max_min, (dn_exp[i] == 0) ? 1 : 0);
            end
        end
        @(negedge clk);
        ent = 1'b0; load_n = 1'b0; d = 4'd0;
        tick();
        check_eq("dn_zero_mm", max_min, 1);
        check_eq("dn_ent0_rco", rco, 0);

        // Load priority and clamp
        @(negedge clk);
        up = 1'b1; enp = 1'b1; ent = 1'b1; load_n = 1'b0; d = 4'd13;
        tick();
        check_eq("load_clamp", q, 9);
        @(negedge clk);
        d = 4'd5;
        tick();
        check_eq("load_5", q, 5);
        @(negedge clk);
        load_n = 1'b1; enp = 1'b0;
        tick();
        check_eq("hold_5", q, 5);

        // Async clear mid-count
        @(negedge clk);
        load_n = 1'b0; d = 4'd6;
        tick();
        check_eq("pre_clr", q, 6);
        load_n = 1'b1; enp = 1'b1; ent = 1'b1;
        #2;
        clr_n = 1'b0;
        #1;
        check_eq("clr_async", q, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("clr_held_%0d", i), q, 0);
        end
        @(negedge clk);
        clr_n = 1'b1;
        tick();
        check_eq("clr_release", q, 1);

        // Power gating
        @(negedge clk);
        load_n = 1'b0; d = 4'd3;
        tick();
        load_n = 1'b1;
        check_eq("pwr_pre", q, 3);
        @(negedge clk);
        vcc = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #1;
        clr_n = 1'b0;
        #2;
        clr_n = 1'b1;
        check_eq("pwr_off_hold", q, 3);
        @(negedge clk);
        vcc = 1'b1;
        tick();
        check_eq("pwr_resume", q, 4);
        @(negedge clk);
        gnd = 1'b1;
        tick();
        check_eq("gnd_bad_hold", q, 4);
        gnd = 1'b0;

        // Cascade of two hex stages
        check_eq("casc_start", {hi_q, lo_q}, 0);
        @(negedge clk);
        c_enp = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            cnt = (cnt + 1) % 256;
            check_eq($sformatf("casc_%0d", i), {hi_q, lo_q}, cnt);
        end
        check_eq("casc_final", {hi_q, lo_q}, 44);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ttl_updown_counter.md
# ttl_updown_counter

Behavioural model of a parametrised synchronous presettable up/down counter, the clocked successor to our fixed-function gate IC models in the TTL library. It generalises the 74160/74161/74190 family: width and modulus are parameters, direction is selectable, and enable/carry pins allow multi-stage cascading. As with the gate models, it responds only when its supply pins are valid. Boards and labs instantiate it wherever a counter IC sits on the schematic.

## Interface
- WIDTH, 4: counter width in bits; legal range 1..16.
- MODULUS, 2**WIDTH: count range is 0..MODULUS-1; legal range 2..2**WIDTH (10 gives decade behaviour).

- CLK  in  1  clock; all state changes occur on the rising edge, except clear.
- CLR_N  in  1  one clock; reset is asynchronous and active-low; clears the counter.
- VCC  in  1  supply pin; device operates only when VCC==1 and GND==0.
- GND  in  1  ground pin.
- LOAD_N  in  1  synchronous parallel load, active-low.
- D  in  WIDTH  parallel load data.
- ENP  in  1  count enable (parallel); does not gate RCO.
- ENT  in  1  count enable (trickle); gates RCO.
- UP  in  1  direction: 1 counts up, 0 counts down.
- Q  out  WIDTH  counter state.
- MAX_MIN  out  1  terminal-count flag: (UP & Q==MODULUS-1) | (~UP & Q==0).
- RCO  out  1  ripple carry: ENT & MAX_MIN.

## Operation
- Powered is VCC==1 && GND==0. When unpowered, CLK edges and CLR_N are ignored and Q holds its value. Q is X at time zero until the first powered clear.
- Priority while powered, highest first:
  - CLR_N==0: Q=0 asynchronously.
  - LOAD_N==0 at the edge: Q=D. ENP and ENT are ignored. If D >= MODULUS, Q=MODULUS-1 (clamped).
  - ENP & ENT at the edge: count by one in direction UP.
  - Otherwise Q holds.
- Count up: MODULUS-1 wraps to 0; otherwise Q+1.
- Count down: 0 wraps to MODULUS-1; otherwise Q-1.
- Arithmetic is modulo MODULUS with no intermediate overflow beyond WIDTH bits.
- MAX_MIN and RCO are combinational from Q, UP and ENT. They are valid whenever Q is defined, regardless of power.
- Reset values (CLR_N low, powered): Q=0, MAX_MIN=~UP, RCO=ENT&~UP.
- Cascade: connect stage n+1 ENT to stage n RCO, with a shared CLK and shared ENP. The upper stage steps exactly once per lower-stage wrap.

## Timing
- Zero-delay model. Q changes in the same timestep as the rising CLK edge, giving one-edge latency from control inputs to Q.
- LOAD_N, D, ENP, ENT and UP are sampled only at the rising edge. Changes between edges have no effect on Q.
- MAX_MIN and RCO follow Q, UP and ENT with no clock delay. A change of UP flips MAX_MIN immediately.
- CLR_N assertion mid-count: Q goes to 0 at once, and edges while CLR_N is low are ignored. After release between edges, the first edge acts normally. A release coinciding with an edge keeps Q at 0 for that edge.
- LOAD_N and count enables both active at an edge: load wins.
- Power loss mid-sequence: Q freezes. On power return, counting resumes from the frozen value on the next qualifying edge.

## Test plan
- Decade count (WIDTH=4, MODULUS=10), powered, CLR_N pulse, then UP=1, ENP=ENT=1 for 12 edges -> Q = 1..9,0,1,2. RCO=1 only while Q==9.
- Down count and wrap: load D=2, then UP=0 for 4 edges -> Q = 1,0,9,8. MAX_MIN=1 only at Q==0. With ENT=0, RCO stays 0 throughout.
- Load priority and clamp: LOAD_N=0, ENP=ENT=1, D=4'd13 -> Q=9 after the edge. With D=4'd5 -> Q=5. With ENP=0 and LOAD_N=1 -> Q holds at 5.
- Async clear mid-count: at Q=6, drop CLR_N between edges -> Q=0 immediately. Three edges while low -> Q stays 0. Release, then one edge -> Q=1.
- Power gating: at Q=3, set VCC=0 and apply 5 edges plus a CLR_N pulse -> Q=3. Restore VCC=1, then one edge -> Q=4.
- Cascade: two WIDTH=4, MODULUS=16 instances, upper ENT = lower RCO, 300 up-edges from 0 -> {upper,lower}=8'd44. Upper changes only on edges where lower==15.
